// File: rtl/sprite_fetch_scheduler_if.sv
// Fetch-port bundle between the line timing, the sprite engines and the fetch scheduler.
// The master side is the scheduler; the slave side is the timing generator plus engines.
interface sprite_fetch_scheduler_if #(
  parameter int NUM_REQ = 16
);
  logic [9:0]         CounterX;
  logic [8:0]         CounterY;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic [3:0]         gnt_idx;
  logic               busy;
  logic [8:0]         line_tag;
  logic               abort;
  logic [7:0]         miss_cnt;

  modport master (
    input  CounterX, CounterY, req, done,
    output gnt, gnt_idx, busy, line_tag, abort, miss_cnt
  );

  modport slave (
    output CounterX, CounterY, req, done,
    input  gnt, gnt_idx, busy, line_tag, abort, miss_cnt
  );
endinterface

// File: rtl/sprite_fetch_scheduler.sv
// Grants the shared sprite-memory fetch port to one engine at a time inside horizontal blanking.
// Define SPRITE_FETCH_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sprite_fetch_scheduler #(
  parameter int NUM_REQ = 16,
  parameter int HACTIVE = 640,
  parameter int HTOTAL  = 800,
  parameter int TIMEOUT = 63
) (
  input logic clk,
  input logic rst,
  sprite_fetch_scheduler_if.master bus
);

  localparam logic [9:0] XOPEN    = 10'(HACTIVE);
  localparam logic [9:0] XLAST    = 10'(HTOTAL - 2);
  localparam logic [9:0] XCLOSE   = 10'(HTOTAL - 1);
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARB, GRANT, GAP} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] served;
  logic [5:0]         tmo;
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
`else
  logic [3:0]         rr;
  logic [3:0]         cand;
`endif

  logic               win;
  logic               win_open;
  logic               win_close;
  logic               done_hit;
  logic               any_elig;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] miss_vec;
  logic [3:0]         winner;
  logic [4:0]         miss_pop;
  logic [8:0]         miss_sum;

  always_comb begin
    win       = (bus.CounterX >= XOPEN) && (bus.CounterX <= XLAST);
    win_open  = (bus.CounterX == XOPEN);
    win_close = (bus.CounterX == XCLOSE);
    done_hit  = (state == GRANT) && bus.done[bus.gnt_idx];
    eligible  = bus.req & ~served;
    // A grant finishing on the closing cycle counts as served, not missed.
    miss_vec  = bus.req & ~served & ~({NUM_REQ{done_hit}} & bus.gnt);
    miss_pop  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      miss_pop = miss_pop + 5'(miss_vec[i]);
    end
    miss_sum  = {1'b0, bus.miss_cnt} + {4'b0, miss_pop};

    winner    = '0;
    any_elig  = 1'b0;
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner   = 4'(i);
        any_elig = 1'b1;
      end
    end
`else
    cand = '0;
    // Scan farthest-first so the engine just after rr is the last hit and wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = rr + 4'(k);
      if (eligible[cand]) begin
        winner   = cand;
        any_elig = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      served       <= '0;
      tmo          <= '0;
      bus.gnt      <= '0;
      bus.gnt_idx  <= '0;
      bus.busy     <= 1'b0;
      bus.line_tag <= '0;
      bus.abort    <= 1'b0;
      bus.miss_cnt <= '0;
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
`else
      rr           <= '0;
`endif
    end else begin
      bus.abort <= 1'b0;
      if (win_open) begin
        served       <= '0;
        bus.line_tag <= bus.CounterY;
      end
      if (!win) begin
        state    <= IDLE;
        bus.gnt  <= '0;
        bus.busy <= 1'b0;
        if (win_close) begin
          bus.miss_cnt <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
          if (state == GRANT) begin
            if (done_hit) begin
              served[bus.gnt_idx] <= 1'b1;
            end else begin
              bus.abort <= 1'b1;
            end
          end
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (win_open) begin
              state <= ARB;
            end
          end
          ARB: begin
            if (any_elig) begin
              bus.gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
              bus.gnt_idx <= winner;
              bus.busy    <= 1'b1;
              tmo         <= '0;
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
`else
              rr          <= winner;
`endif
              state       <= GRANT;
            end
          end
          GRANT: begin
            if (done_hit) begin
              bus.gnt             <= '0;
              bus.busy            <= 1'b0;
              served[bus.gnt_idx] <= 1'b1;
              state               <= GAP;
            end else if (tmo == TMO_LAST) begin
              bus.gnt             <= '0;
              bus.busy            <= 1'b0;
              bus.abort           <= 1'b1;
              served[bus.gnt_idx] <= 1'b1;
              state               <= GAP;
            end else begin
              tmo <= tmo + 6'd1;
            end
          end
          GAP: begin
            state <= ARB;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Self-checking bench for sprite_fetch_scheduler: directed vector table, corner sequences,
// and randomized traffic compared every cycle against a grant/owner-level reference model.
module tb_sprite_fetch_scheduler;

  localparam int NUM_REQ = 16;
  localparam int HACTIVE = 640;
  localparam int HTOTAL  = 800;
  localparam int TIMEOUT = 63;

  typedef struct {
    int          cx;
    logic [15:0] done;
    logic [15:0] gnt;
    logic        busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cx = 620;
  int   cy = 5;

  int          m_owner;
  int          m_age;
  int          m_cool;
  bit          m_active;
  bit   [15:0] m_served;
  int          m_rr;
  logic [7:0]  m_miss;
  logic [8:0]  m_tag;
  logic        m_abort;

  sprite_fetch_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  sprite_fetch_scheduler #(
    .NUM_REQ(NUM_REQ),
    .HACTIVE(HACTIVE),
    .HTOTAL (HTOTAL),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t cx=%0d actual=%h expected=%h", name, $time, cx, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_age    = 0;
    m_cool   = 0;
    m_active = 1'b0;
    m_served = '0;
    m_rr     = 0;
    m_miss   = '0;
    m_tag    = '0;
    m_abort  = 1'b0;
  endtask

  function automatic int pick(input logic [15:0] elig, input int rr);
    int         w;
    logic [3:0] j;
    w = -1;
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      j = 4'(i);
      if (elig[j] && w < 0) w = i;
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = 4'((rr + k) % NUM_REQ);
      if (elig[j] && w < 0) w = (rr + k) % NUM_REQ;
    end
`endif
    return w;
  endfunction

  // Advances the model over one clock using the inputs currently driven.
  task automatic model_step();
    logic [15:0] r;
    logic [15:0] d;
    int          cnt;
    int          s;
    int          w;
    bit          completing;
    r = bus.req;
    d = bus.done;
    m_abort = 1'b0;
    if (cx == HACTIVE) begin
      m_served = '0;
      m_tag    = 9'(cy);
    end
    if (cx < HACTIVE || cx > HTOTAL - 2) begin
      if (cx == HTOTAL - 1) begin
        completing = (m_owner >= 0) && d[4'(m_owner)];
        cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (r[i] && !m_served[i] && !(completing && i == m_owner)) cnt++;
        end
        s = int'(m_miss) + cnt;
        m_miss = (s > 255) ? 8'hFF : 8'(s);
        if (m_owner >= 0 && !completing) m_abort = 1'b1;
      end
      m_owner  = -1;
      m_active = 1'b0;
    end else if (!m_active) begin
      if (cx == HACTIVE) begin
        m_active = 1'b1;
        m_cool   = 0;
      end
    end else if (m_owner >= 0) begin
      if (d[4'(m_owner)]) begin
        m_served[4'(m_owner)] = 1'b1;
        m_owner = -1;
        m_cool  = 1;
      end else if (m_age == TIMEOUT - 1) begin
        m_served[4'(m_owner)] = 1'b1;
        m_abort = 1'b1;
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_age++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      w = pick(r & ~m_served, m_rr);
      if (w >= 0) begin
        m_owner = w;
        m_age   = 0;
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
`else
        m_rr    = w;
`endif
      end
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [15:0] g;
    logic        b;
    b = (m_owner >= 0);
    g = b ? (16'h1 << m_owner) : 16'h0;
    return {25'h0, g, b, m_abort, m_miss, m_tag, b ? 4'(m_owner) : 4'h0};
  endfunction

  task automatic advance();
    if (cx == HTOTAL - 1) begin
      cx = 0;
      cy = (cy + 1) % 512;
    end else begin
      cx++;
    end
    bus.CounterX = 10'(cx);
    bus.CounterY = 9'(cy);
    bus.done     = '0;
  endtask

  task automatic step_cycle();
    logic [63:0] act;
    model_step();
    @(posedge clk);
    #1;
    act = {25'h0, bus.gnt, bus.busy, bus.abort, bus.miss_cnt, bus.line_tag,
           bus.busy ? bus.gnt_idx : 4'h0};
    check_output("model", act, model_vec());
    advance();
  endtask

  task automatic go_to(input int x);
    do step_cycle(); while (cx != x);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    check_output("rst_gnt", 64'(bus.gnt), 64'h0);
    check_output("rst_busy", 64'(bus.busy), 64'h0);
    check_output("rst_abort", 64'(bus.abort), 64'h0);
    check_output("rst_miss", 64'(bus.miss_cnt), 64'h0);
    check_output("rst_tag", 64'(bus.line_tag), 64'h0);
    check_output("rst_idx", 64'(bus.gnt_idx), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    advance();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus();
    if ($urandom_range(0, 39) == 0) bus.req = 16'($urandom) & 16'($urandom);
    if (bus.busy && $urandom_range(0, 24) == 0) bus.done = bus.gnt;
    if ($urandom_range(0, 15) == 0) bus.done = bus.done | (16'h1 << $urandom_range(0, 15));
  endtask

  initial begin
    vec_t        tbl[8];
    logic [15:0] first_g;
    logic [15:0] second_g;
    int          held;
    int          line;
    int          exp_miss;

    bus.req      = '0;
    bus.done     = '0;
    bus.CounterX = 10'(cx);
    bus.CounterY = 9'(cy);
`ifdef SPRITE_FETCH_FIXED_PRIO_EN
    first_g  = 16'h0001;
    second_g = 16'h0004;
`else
    first_g  = 16'h0004;
    second_g = 16'h0001;
`endif
    tbl[0] = '{641, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{642, 16'h0000, first_g,  1'b1};
    tbl[2] = '{645, 16'h0000, first_g,  1'b1};
    tbl[3] = '{650, first_g,  first_g,  1'b1};
    tbl[4] = '{651, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{652, 16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{653, 16'h0000, second_g, 1'b1};
    tbl[7] = '{660, second_g, second_g, 1'b1};

    apply_reset();

    bus.req = 16'h0005;
    for (int i = 0; i < 8; i++) begin
      while (cx != tbl[i].cx) step_cycle();
      bus.done = tbl[i].done;
      check_output("tbl_gnt", 64'(bus.gnt), 64'(tbl[i].gnt));
      check_output("tbl_busy", 64'(bus.busy), 64'(tbl[i].busy));
    end
    check_output("line_tag", 64'(bus.line_tag), 64'd5);
    go_to(700);
    check_output("no_regrant", 64'(bus.gnt), 64'h0);
    go_to(0);
    check_output("miss_a", 64'(bus.miss_cnt), 64'h0);

    // Engine 5 never finishes: grant must drop after 63 cycles with an abort pulse.
    bus.req = 16'h0020;
    go_to(704);
    check_output("tmo_hold", 64'(bus.gnt), 64'h20);
    step_cycle();
    check_output("tmo_gnt", 64'(bus.gnt), 64'h0);
    check_output("tmo_abort", 64'(bus.abort), 64'h1);
    check_output("tmo_busy", 64'(bus.busy), 64'h0);
    step_cycle();
    check_output("tmo_abort_end", 64'(bus.abort), 64'h0);
    go_to(720);
    check_output("tmo_no_regrant", 64'(bus.gnt), 64'h0);

    go_to(0);
    go_to(704);
    bus.done = 16'h0020;
    check_output("tie_hold", 64'(bus.gnt), 64'h20);
    step_cycle();
    check_output("tie_gnt", 64'(bus.gnt), 64'h0);
    check_output("tie_abort", 64'(bus.abort), 64'h0);
    go_to(720);
    check_output("tie_no_regrant", 64'(bus.gnt), 64'h0);

    go_to(0);
    bus.req = 16'h0004;
    go_to(650);
    bus.done = 16'h0080;
    check_output("ign_pre", 64'(bus.gnt), 64'h4);
    step_cycle();
    check_output("ign_gnt", 64'(bus.gnt), 64'h4);
    check_output("ign_busy", 64'(bus.busy), 64'h1);
    go_to(660);
    bus.done = 16'h0004;
    step_cycle();
    check_output("ign_release", 64'(bus.gnt), 64'h0);
    go_to(0);
    check_output("miss_d", 64'(bus.miss_cnt), 64'h0);

    for (int n = 0; n < 15 * HTOTAL; n++) begin
      step_cycle();
      apply_stimulus();
    end

    bus.req = '0;
    apply_reset();

    // Every engine needs 20 cycles: 7 fit per window, the 8th is killed, 9 missed per line.
    held = 0;
    line = 0;
    go_to(0);
    bus.req = 16'hFFFF;
    while (line < 30) begin
      step_cycle();
      if (bus.busy) held++;
      else held = 0;
      if (held == 20) bus.done = bus.gnt;
      if (cx == 0) begin
        line++;
        exp_miss = (9 * line > 255) ? 255 : 9 * line;
        check_output("miss_sat", 64'(bus.miss_cnt), 64'(exp_miss));
        if (line == 1) check_output("close_abort", 64'(bus.abort), 64'h1);
      end
    end

    bus.req = 16'h0008;
    go_to(645);
    check_output("pre_reset_gnt", 64'(bus.gnt), 64'h8);
    apply_reset();
    go_to(0);
    go_to(700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
